// File: rtl/mult_reservation_station_pkg.sv
// Shared types for the multiply reservation station: the issued op, the CDB broadcast
// and the queued entry (op plus per-source physical tag and ready bit).
package mult_reservation_station_pkg;

  localparam int MULT_RS_DEPTH_DEFAULT = 4;
  localparam int NUM_CDB_DEFAULT       = 3;
  localparam int XLEN                  = 32;
  localparam int PHYS_W                = 6;
  localparam int ROB_W                 = 5;

  typedef enum logic [1:0] {
    MUL_OP_MUL,
    MUL_OP_MULH,
    MUL_OP_MULHSU,
    MUL_OP_MULHU
  } mult_op_e;

  typedef struct packed {
    mult_op_e              op_type;
    logic [ROB_W-1:0]      rob_index;
    logic [PHYS_W-1:0]     phys_rd;
    logic [XLEN-1:0]       rs1_v;
    logic [XLEN-1:0]       rs2_v;
  } functional_unit_t;

  typedef struct packed {
    logic                  valid;
    logic [PHYS_W-1:0]     commit_phys_rd_addr;
    logic [XLEN-1:0]       data;
  } cdb_output_t;

  typedef struct packed {
    functional_unit_t      op;
    logic [PHYS_W-1:0]     rs1_phys;
    logic                  rs1_ready;
    logic [PHYS_W-1:0]     rs2_phys;
    logic                  rs2_ready;
  } mult_rs_entry_t;

endpackage

// File: rtl/mult_reservation_station_if.sv
// Dispatch, wakeup and issue signals between rename/dispatch, the CDB, the reservation
// station (slave) and the multiply unit.
interface mult_reservation_station_if
  import mult_reservation_station_pkg::*;
#(
  parameter int NUM_CDB = NUM_CDB_DEFAULT
) ();

  // Handshake: a dispatch_valid op is taken at the clock edge iff rs_full is low and no
  // flush is active; there is no other back-pressure. issue_start is a single-cycle
  // strobe that the multiply unit must accept; it holds issue off via mult_in_use/stall.
  logic                           dispatch_valid;
  mult_rs_entry_t                 dispatch_entry;
  logic                           rs_full;
  cdb_output_t [NUM_CDB-1:0]      cdb;
  logic                           mult_in_use;
  logic                           stall;
  logic                           issue_start;
  functional_unit_t               issue_op;

  modport master (
    output dispatch_valid, dispatch_entry, cdb, mult_in_use, stall,
    input  rs_full, issue_start, issue_op
  );

  modport slave (
    input  dispatch_valid, dispatch_entry, cdb, mult_in_use, stall,
    output rs_full, issue_start, issue_op
  );

endinterface

// File: rtl/mult_rs_wakeup.sv
// Compares one source tag against every CDB port; a pending, non-zero tag that matches
// a valid broadcast reports a hit and the broadcast data (lowest port wins).
module mult_rs_wakeup
  import mult_reservation_station_pkg::*;
#(
  parameter int NUM_CDB = NUM_CDB_DEFAULT
) (
  input  logic [PHYS_W-1:0]         tag_i,
  input  logic                      ready_i,
  input  cdb_output_t [NUM_CDB-1:0] cdb_i,
  output logic                      hit_o,
  output logic [XLEN-1:0]           data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (!ready_i && (tag_i != '0)) begin
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (cdb_i[i].valid && (cdb_i[i].commit_phys_rd_addr == tag_i)) begin
          hit_o  = 1'b1;
          data_o = cdb_i[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/mult_reservation_station.sv
// Collapsing-queue reservation station for the multiply unit (slot 0 oldest).
// Define MULT_RS_WAKEUP_BYPASS_EN to let a source woken this cycle issue in the same cycle.
module mult_reservation_station
  import mult_reservation_station_pkg::*;
#(
  parameter int MULT_RS_DEPTH = MULT_RS_DEPTH_DEFAULT,
  parameter int NUM_CDB       = NUM_CDB_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  mult_reservation_station_if.slave bus
);

  localparam int SEL_W = (MULT_RS_DEPTH > 1) ? $clog2(MULT_RS_DEPTH) : 1;
  localparam int CNT_W = $clog2(MULT_RS_DEPTH + 1);

  logic [MULT_RS_DEPTH-1:0] valid_q, valid_d;
  mult_rs_entry_t           slot_q [MULT_RS_DEPTH];
  mult_rs_entry_t           slot_d [MULT_RS_DEPTH];
  mult_rs_entry_t           woken  [MULT_RS_DEPTH];

  logic [MULT_RS_DEPTH-1:0] hit1, hit2, elig;
  logic [XLEN-1:0]          data1 [MULT_RS_DEPTH];
  logic [XLEN-1:0]          data2 [MULT_RS_DEPTH];
  logic                     disp_hit1, disp_hit2;
  logic [XLEN-1:0]          disp_data1, disp_data2;
  mult_rs_entry_t           disp_woken;

  logic                     any_elig, issue_start, disp_accept, rs_full;
  logic [SEL_W-1:0]         sel;
  logic [CNT_W-1:0]         count, disp_pos;

  for (genvar s = 0; s < MULT_RS_DEPTH; s++) begin : g_slot
    mult_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_w1 (
      .tag_i(slot_q[s].rs1_phys), .ready_i(slot_q[s].rs1_ready), .cdb_i(bus.cdb),
      .hit_o(hit1[s]), .data_o(data1[s])
    );
    mult_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_w2 (
      .tag_i(slot_q[s].rs2_phys), .ready_i(slot_q[s].rs2_ready), .cdb_i(bus.cdb),
      .hit_o(hit2[s]), .data_o(data2[s])
    );
  end

  // The op being dispatched snoops the same broadcasts so no wakeup is lost in flight.
  mult_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_disp_w1 (
    .tag_i(bus.dispatch_entry.rs1_phys), .ready_i(bus.dispatch_entry.rs1_ready),
    .cdb_i(bus.cdb), .hit_o(disp_hit1), .data_o(disp_data1)
  );
  mult_rs_wakeup #(.NUM_CDB(NUM_CDB)) u_disp_w2 (
    .tag_i(bus.dispatch_entry.rs2_phys), .ready_i(bus.dispatch_entry.rs2_ready),
    .cdb_i(bus.cdb), .hit_o(disp_hit2), .data_o(disp_data2)
  );

  always_comb begin
    for (int s = 0; s < MULT_RS_DEPTH; s++) begin
      woken[s] = slot_q[s];
      if (hit1[s]) begin
        woken[s].rs1_ready = 1'b1;
        woken[s].op.rs1_v  = data1[s];
      end
      if (hit2[s]) begin
        woken[s].rs2_ready = 1'b1;
        woken[s].op.rs2_v  = data2[s];
      end
    end
    disp_woken = bus.dispatch_entry;
    if (disp_hit1) begin
      disp_woken.rs1_ready = 1'b1;
      disp_woken.op.rs1_v  = disp_data1;
    end
    if (disp_hit2) begin
      disp_woken.rs2_ready = 1'b1;
      disp_woken.op.rs2_v  = disp_data2;
    end
  end

  always_comb begin
    elig  = '0;
    sel   = '0;
    count = '0;
    for (int s = 0; s < MULT_RS_DEPTH; s++) begin
`ifdef MULT_RS_WAKEUP_BYPASS_EN
      elig[s] = valid_q[s] && woken[s].rs1_ready && woken[s].rs2_ready;
`else
      elig[s] = valid_q[s] && slot_q[s].rs1_ready && slot_q[s].rs2_ready;
`endif
      count = count + CNT_W'(valid_q[s]);
    end
    for (int s = MULT_RS_DEPTH - 1; s >= 0; s--) begin
      if (elig[s]) sel = SEL_W'(s);
    end
  end

  assign any_elig    = |elig;
  assign rs_full     = &valid_q;
  assign issue_start = any_elig && !bus.mult_in_use && !bus.stall && !flush && !rst;
  assign disp_accept = bus.dispatch_valid && !rs_full && !flush;
  // After the collapse the queue holds count-1 entries, so the new op lands just above them.
  assign disp_pos    = count - CNT_W'(issue_start);

  assign bus.rs_full     = rs_full;
  assign bus.issue_start = issue_start;
  assign bus.issue_op    = issue_start ? woken[sel].op : '0;

  always_comb begin
    valid_d = valid_q;
    slot_d  = woken;
    if (issue_start) begin
      for (int s = 0; s < MULT_RS_DEPTH - 1; s++) begin
        if (SEL_W'(s) >= sel) begin
          slot_d[s]  = woken[s+1];
          valid_d[s] = valid_q[s+1];
        end
      end
      valid_d[MULT_RS_DEPTH-1] = 1'b0;
    end
    if (disp_accept) begin
      for (int s = 0; s < MULT_RS_DEPTH; s++) begin
        if (CNT_W'(s) == disp_pos) begin
          slot_d[s]  = disp_woken;
          valid_d[s] = 1'b1;
        end
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
    slot_q <= slot_d;
  end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Bench for mult_reservation_station: directed scenarios plus randomized traffic checked
// against an age-ordered queue model (honours MULT_RS_WAKEUP_BYPASS_EN).
module tb_mult_reservation_station;
  import mult_reservation_station_pkg::*;

  localparam int DEPTH = 4;
  localparam int NC    = 3;
  typedef cdb_output_t [NC-1:0] cdb_vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  mult_reservation_station_if #(.NUM_CDB(NC)) bus ();

  mult_reservation_station #(.MULT_RS_DEPTH(DEPTH), .NUM_CDB(NC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  mult_rs_entry_t   model_q[$];
  mult_rs_entry_t   nxt_q[$];
  logic             exp_start, exp_full;
  functional_unit_t exp_op;
  logic [ROB_W-1:0] exp_q[$];
  cdb_vec_t         no_cdb = '0;
  mult_rs_entry_t   no_e   = '0;

  function automatic mult_rs_entry_t mk(input int rob, input int t1, input logic r1, input int v1,
                                        input int t2, input logic r2, input int v2);
    mult_rs_entry_t e;
    e              = '0;
    e.op.op_type   = MUL_OP_MUL;
    e.op.rob_index = ROB_W'(rob);
    e.op.phys_rd   = PHYS_W'(rob + 32);
    e.op.rs1_v     = XLEN'(v1);
    e.op.rs2_v     = XLEN'(v2);
    e.rs1_phys     = PHYS_W'(t1);
    e.rs1_ready    = r1;
    e.rs2_phys     = PHYS_W'(t2);
    e.rs2_ready    = r2;
    return e;
  endfunction

  function automatic cdb_vec_t bcast(input int port, input int tag, input int data);
    cdb_vec_t v;
    v = '0;
    v[port].valid               = 1'b1;
    v[port].commit_phys_rd_addr = PHYS_W'(tag);
    v[port].data                = XLEN'(data);
    return v;
  endfunction

  // A pending non-zero tag takes the data of the first valid CDB port carrying it.
  function automatic mult_rs_entry_t wake(input mult_rs_entry_t e, input cdb_vec_t cv);
    mult_rs_entry_t r;
    logic f1, f2;
    r  = e;
    f1 = 1'b0;
    f2 = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (!e.rs1_ready && !f1 && e.rs1_phys != '0 && cv[i].valid && cv[i].commit_phys_rd_addr == e.rs1_phys) begin
        f1 = 1'b1;
        r.op.rs1_v = cv[i].data;
      end
      if (!e.rs2_ready && !f2 && e.rs2_phys != '0 && cv[i].valid && cv[i].commit_phys_rd_addr == e.rs2_phys) begin
        f2 = 1'b1;
        r.op.rs2_v = cv[i].data;
      end
    end
    if (f1) r.rs1_ready = 1'b1;
    if (f2) r.rs2_ready = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic r, input logic fl, input logic dv, input mult_rs_entry_t de,
                       input cdb_vec_t cv, input logic miu, input logic st);
    int pick;
    logic ok;
    mult_rs_entry_t e;
    @(negedge clk);
    rst                = r;
    flush              = fl;
    bus.dispatch_valid = dv;
    bus.dispatch_entry = de;
    bus.cdb            = cv;
    bus.mult_in_use    = miu;
    bus.stall          = st;
    pick     = -1;
    exp_full = (model_q.size() == DEPTH);
    foreach (model_q[i]) begin
      e = wake(model_q[i], cv);
`ifdef MULT_RS_WAKEUP_BYPASS_EN
      ok = e.rs1_ready && e.rs2_ready;
`else
      ok = model_q[i].rs1_ready && model_q[i].rs2_ready;
`endif
      if (ok && pick < 0) pick = i;
    end
    exp_start = (pick >= 0) && !miu && !st && !fl && !r;
    exp_op    = '0;
    if (exp_start) begin
      e      = wake(model_q[pick], cv);
      exp_op = e.op;
    end
    nxt_q.delete();
    if (!r && !fl) begin
      foreach (model_q[i]) begin
        if (!(exp_start && i == pick)) nxt_q.push_back(wake(model_q[i], cv));
      end
      if (dv && !exp_full) nxt_q.push_back(wake(de, cv));
    end
    #1;
  endtask

  task automatic advance();
    model_q = nxt_q;
    @(posedge clk);
  endtask

  task automatic idle(input logic miu, input logic st);
    drive(1'b0, 1'b0, 1'b0, no_e, no_cdb, miu, st);
  endtask

  task automatic disp(input mult_rs_entry_t de, input logic miu);
    drive(1'b0, 1'b0, 1'b1, de, no_cdb, miu, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, no_e, no_cdb, 1'b0, 1'b0); advance();
    drive(1'b1, 1'b0, 1'b0, no_e, no_cdb, 1'b0, 1'b0); advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL reset_start got=%0b exp=0", bus.issue_start); else n_pass++;
    n_checks++; if (bus.issue_op !== '0) $display("FAIL reset_op got=%h exp=0", bus.issue_op); else n_pass++;
    n_checks++; if (bus.rs_full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", bus.rs_full); else n_pass++;
    advance();
  endtask

  task automatic test_basic_issue();
    disp(mk(1, 5, 1'b1, 7, 6, 1'b1, 3), 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL basic_empty got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b1) $display("FAIL basic_start got=%0b exp=1", bus.issue_start); else n_pass++;
    n_checks++; if (bus.issue_op.rs1_v !== 32'd7) $display("FAIL basic_rs1 got=%0d exp=7", bus.issue_op.rs1_v); else n_pass++;
    n_checks++; if (bus.issue_op.rs2_v !== 32'd3) $display("FAIL basic_rs2 got=%0d exp=3", bus.issue_op.rs2_v); else n_pass++;
    n_checks++; if (bus.issue_op.rob_index !== 5'd1) $display("FAIL basic_rob got=%0d exp=1", bus.issue_op.rob_index); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL basic_drained got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
  endtask

  task automatic test_wakeup();
    disp(mk(2, 5, 1'b1, 4, 9, 1'b0, 0), 1'b0); advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL wake_wait got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    drive(1'b0, 1'b0, 1'b0, no_e, bcast(1, 9, 'h10), 1'b0, 1'b0);
`ifndef MULT_RS_WAKEUP_BYPASS_EN
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL wake_same_cycle got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
`endif
    n_checks++; if (bus.issue_start !== 1'b1) $display("FAIL wake_start got=%0b exp=1", bus.issue_start); else n_pass++;
    n_checks++; if (bus.issue_op.rs2_v !== 32'h10) $display("FAIL wake_rs2 got=%h exp=10", bus.issue_op.rs2_v); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL wake_drained got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
  endtask

  task automatic test_full_order();
    logic [ROB_W-1:0] want;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      disp(mk(i + 8, 1, 1'b1, i + 1, 2, 1'b1, i + 2), 1'b1);
      n_checks++; if (bus.rs_full !== 1'b0) $display("FAIL fill_full%0d got=%0b exp=0", i, bus.rs_full); else n_pass++;
      exp_q.push_back(ROB_W'(i + 8));
      advance();
    end
    disp(mk(20, 1, 1'b1, 1, 2, 1'b1, 1), 1'b1);
    n_checks++; if (bus.rs_full !== 1'b1) $display("FAIL full_flag got=%0b exp=1", bus.rs_full); else n_pass++;
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL full_busy got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b0, 1'b0);
      want = exp_q.pop_front();
      n_checks++; if (bus.issue_start !== 1'b1) $display("FAIL order_start%0d got=%0b exp=1", i, bus.issue_start); else n_pass++;
      n_checks++; if (bus.issue_op.rob_index !== want) $display("FAIL order_rob%0d got=%0d exp=%0d", i, bus.issue_op.rob_index, want); else n_pass++;
      advance();
    end
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL full_dropped got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
  endtask

  task automatic test_out_of_order();
    disp(mk(4, 20, 1'b0, 0, 6, 1'b1, 2), 1'b0); advance();
    disp(mk(5, 7, 1'b1, 3, 8, 1'b1, 4), 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL ooo_old_wait got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_op.rob_index !== 5'd5 || bus.issue_start !== 1'b1) $display("FAIL ooo_young got=%0b/%0d exp=1/5", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    advance();
    drive(1'b0, 1'b0, 1'b0, no_e, bcast(0, 20, 'h55), 1'b0, 1'b0);
`ifndef MULT_RS_WAKEUP_BYPASS_EN
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL ooo_same_cycle got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
`endif
    n_checks++; if (bus.issue_op.rob_index !== 5'd4 || bus.issue_start !== 1'b1) $display("FAIL ooo_old got=%0b/%0d exp=1/4", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    n_checks++; if (bus.issue_op.rs1_v !== 32'h55) $display("FAIL ooo_old_rs1 got=%h exp=55", bus.issue_op.rs1_v); else n_pass++;
    advance();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      disp(mk(i + 12, 1, 1'b1, 1, 2, 1'b1, 1), 1'b1); advance();
    end
    drive(1'b0, 1'b1, 1'b1, mk(15, 1, 1'b1, 1, 2, 1'b1, 1), no_cdb, 1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL flush_issue got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL flush_empty got=%0b exp=0", bus.issue_start); else n_pass++;
    n_checks++; if (bus.rs_full !== 1'b0) $display("FAIL flush_full got=%0b exp=0", bus.rs_full); else n_pass++;
    advance();
    disp(mk(16, 1, 1'b1, 2, 2, 1'b1, 3), 1'b0); advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_op.rob_index !== 5'd16 || bus.issue_start !== 1'b1) $display("FAIL flush_after got=%0b/%0d exp=1/16", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    advance();
  endtask

  task automatic test_stall();
    disp(mk(17, 1, 1'b1, 5, 2, 1'b1, 6), 1'b0); advance();
    for (int i = 0; i < 2; i++) begin
      idle(1'b0, 1'b1);
      n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL stall_hold%0d got=%0b exp=0", i, bus.issue_start); else n_pass++;
      n_checks++; if (bus.issue_op !== '0) $display("FAIL stall_op%0d got=%h exp=0", i, bus.issue_op); else n_pass++;
      advance();
    end
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_op.rob_index !== 5'd17 || bus.issue_start !== 1'b1) $display("FAIL stall_release got=%0b/%0d exp=1/17", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    disp(mk(21, 1, 1'b1, 1, 2, 1'b1, 1), 1'b1); advance();
    disp(mk(22, 1, 1'b1, 2, 2, 1'b1, 2), 1'b1); advance();
    disp(mk(23, 1, 1'b1, 3, 2, 1'b1, 3), 1'b0);
    n_checks++; if (bus.issue_op.rob_index !== 5'd21 || bus.issue_start !== 1'b1) $display("FAIL b2b_first got=%0b/%0d exp=1/21", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_op.rob_index !== 5'd22 || bus.issue_start !== 1'b1) $display("FAIL b2b_second got=%0b/%0d exp=1/22", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_op.rob_index !== 5'd23 || bus.issue_start !== 1'b1) $display("FAIL b2b_third got=%0b/%0d exp=1/23", bus.issue_start, bus.issue_op.rob_index); else n_pass++;
    advance();
  endtask

  task automatic test_dispatch_wakeup();
    drive(1'b0, 1'b0, 1'b1, mk(24, 30, 1'b0, 0, 5, 1'b1, 1), bcast(2, 30, 'h99), 1'b0, 1'b0); advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.issue_start !== 1'b1) $display("FAIL dwake_start got=%0b exp=1", bus.issue_start); else n_pass++;
    n_checks++; if (bus.issue_op.rs1_v !== 32'h99) $display("FAIL dwake_rs1 got=%h exp=99", bus.issue_op.rs1_v); else n_pass++;
    advance();
    drive(1'b0, 1'b0, 1'b1, mk(25, 0, 1'b0, 0, 5, 1'b1, 1), bcast(0, 0, 'h77), 1'b0, 1'b0); advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, no_e, bcast(1, 0, 'h77), 1'b0, 1'b0);
      n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL tag0_no_wake%0d got=%0b exp=0", i, bus.issue_start); else n_pass++;
      advance();
    end
    drive(1'b0, 1'b1, 1'b0, no_e, no_cdb, 1'b0, 1'b0); advance();
  endtask

  task automatic test_reset_mid();
    disp(mk(26, 40, 1'b0, 0, 5, 1'b1, 1), 1'b0); advance();
    drive(1'b1, 1'b1, 1'b1, mk(27, 1, 1'b1, 1, 2, 1'b1, 1), bcast(0, 40, 'h33), 1'b0, 1'b0); advance();
    for (int i = 0; i < 2; i++) begin
      idle(1'b0, 1'b0);
      n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL rstmid_issue%0d got=%0b exp=0", i, bus.issue_start); else n_pass++;
      advance();
    end
    for (int i = 0; i < DEPTH; i++) begin
      disp(mk(i, 1, 1'b1, 1, 2, 1'b1, 1), 1'b1); advance();
    end
    drive(1'b1, 1'b0, 1'b0, no_e, no_cdb, 1'b0, 1'b0); advance();
    idle(1'b0, 1'b0);
    n_checks++; if (bus.rs_full !== 1'b0) $display("FAIL rstfull_full got=%0b exp=0", bus.rs_full); else n_pass++;
    n_checks++; if (bus.issue_start !== 1'b0) $display("FAIL rstfull_issue got=%0b exp=0", bus.issue_start); else n_pass++;
    advance();
  endtask

  task automatic test_random();
    int t1, t2, v1, v2;
    logic r1, r2;
    cdb_vec_t cv;
    for (int c = 0; c < 600; c++) begin
      t1 = $urandom_range(0, 15);
      t2 = $urandom_range(0, 15);
      r1 = (t1 == 0) || ($urandom_range(0, 1) == 1);
      r2 = (t2 == 0) || ($urandom_range(0, 1) == 1);
      v1 = (r1 && t1 != 0) ? int'($urandom) : 0;
      v2 = (r2 && t2 != 0) ? int'($urandom) : 0;
      for (int i = 0; i < NC; i++) begin
        cv[i].valid               = ($urandom_range(0, 2) == 0);
        cv[i].commit_phys_rd_addr = PHYS_W'($urandom_range(0, 15));
        cv[i].data                = $urandom;
      end
      drive(($urandom_range(0, 80) == 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1),
            mk(c % 32, t1, r1, v1, t2, r2, v2), cv,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
      n_checks++;
      if ({bus.issue_start, bus.issue_op, bus.rs_full} !== {exp_start, exp_op, exp_full})
        $display("FAIL random c=%0d got start=%0b op=%h full=%0b exp start=%0b op=%h full=%0b",
                 c, bus.issue_start, bus.issue_op, bus.rs_full, exp_start, exp_op, exp_full);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    bus.dispatch_valid = 1'b0;
    bus.dispatch_entry = '0;
    bus.cdb            = '0;
    bus.mult_in_use    = 1'b0;
    bus.stall          = 1'b0;
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full_order();
    test_out_of_order();
    test_flush();
    test_stall();
    test_back_to_back();
    test_dispatch_wakeup();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
